// File: rtl/scan_loader.sv
// ============================================================================
//  Module   : scan_loader
//  Purpose  : Serial-scan master that shifts one full pattern buffer
//             (buffer_size bytes, byte 0 first, MSB first) into the buffer
//             chain selected by saddr, using sclk/sin/ssel.
//  Options  : SCAN_READBACK_EN - capture the returned sout stream into bytes
//             on rd_data/rd_valid. Undefined: rd_* tied to 0, sout unused.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_loader #(
    parameter int buffer_size  = 32,
    parameter int buffer_width = 8,
    parameter int sclk_div     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              start_addr,
    input  logic [buffer_width-1:0] byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    sin,
    output logic                    ssel,
    output logic [2:0]              saddr,
    input  logic                    sout,
    output logic [buffer_width-1:0] rd_data,
    output logic                    rd_valid
);

    localparam int CNT_W  = (sclk_div > 1) ? $clog2(sclk_div) : 1;
    localparam int BYTE_W = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam int BIT_W  = $clog2(buffer_width);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(sclk_div - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(buffer_size - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(buffer_width - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BIT_W-1:0]        bit_q;
    logic [BYTE_W-1:0]       byte_q;
    // Only the bits still to be sent are kept; the MSB is already on sin.
    logic [buffer_width-2:0] shreg_q;
    logic [2:0]              saddr_q;
    logic                    sclk_q;
    logic                    sin_q;
    logic                    ssel_q;
    logic                    busy_q;
    logic                    byte_ready_q;
    logic                    done_q;

    // Frame sequencer: every scan output is a flop so sclk cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            shreg_q      <= '0;
            saddr_q      <= '0;
            sclk_q       <= 1'b0;
            sin_q        <= 1'b0;
            ssel_q       <= 1'b0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        saddr_q      <= start_addr;
                        ssel_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (byte_valid && byte_ready_q) begin
                        shreg_q      <= byte_in[buffer_width-2:0];
                        sin_q        <= byte_in[buffer_width-1];
                        bit_q        <= BIT_TOP;
                        cnt_q        <= '0;
                        byte_ready_q <= 1'b0;
                        state_q      <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_q != '0) begin
                            bit_q   <= bit_q - BIT_W'(1);
                            sin_q   <= shreg_q[buffer_width-2];
                            shreg_q <= {shreg_q[buffer_width-3:0], 1'b0};
                            state_q <= ST_LOW;
                        end else if (byte_q != BYTE_LAST) begin
                            byte_q       <= byte_q + BYTE_W'(1);
                            byte_ready_q <= 1'b1;
                            state_q      <= ST_LOAD;
                        end else begin
                            byte_q  <= '0;
                            ssel_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sclk       = sclk_q;
    assign sin        = sin_q;
    assign ssel       = ssel_q;
    assign saddr      = saddr_q;

`ifdef SCAN_READBACK_EN
    logic [buffer_width-2:0] rd_sh_q;
    logic [buffer_width-1:0] rd_data_q;
    logic                    rd_valid_q;
    logic                    w_sample;

    // sout is taken in the last LOW cycle, just before the sclk rise.
    assign w_sample = (state_q == ST_LOW) && (cnt_q == CNT_LAST);

    // Readback capture: bit_q == 0 marks the final bit of the byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sh_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (w_sample) begin
                rd_sh_q <= {rd_sh_q[buffer_width-3:0], sout};
                if (bit_q == '0) begin
                    rd_data_q  <= {rd_sh_q, sout};
                    rd_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic w_unused_sout;

    assign w_unused_sout = sout;
    assign rd_data       = '0;
    assign rd_valid      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_loader.sv
// ============================================================================
//  Module   : tb_scan_loader
//  Purpose  : Directed self-checking bench for scan_loader (default divider
//             instance plus an sclk_div=1 instance).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    // default instance (sclk_div = 2)
    logic       start = 1'b0;
    logic [2:0] start_addr = 3'd0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       sout = 1'b0;
    logic       byte_ready, busy, done, sclk, sin, ssel, rd_valid;
    logic [2:0] saddr;
    logic [7:0] rd_data;

    // sclk_div = 1 instance
    logic       start1 = 1'b0;
    logic       byte_valid1 = 1'b0;
    logic [7:0] byte_in1 = 8'hC3;
    logic       byte_ready1, busy1, done1, sclk1, sin1, ssel1, rd_valid1;
    logic [2:0] saddr1;
    logic [7:0] rd_data1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    scan_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done), .sclk(sclk), .sin(sin), .ssel(ssel),
        .saddr(saddr), .sout(sout), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    scan_loader #(.buffer_size(32), .buffer_width(8), .sclk_div(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .start_addr(3'd1),
        .byte_in(byte_in1), .byte_valid(byte_valid1), .byte_ready(byte_ready1),
        .busy(busy1), .done(done1), .sclk(sclk1), .sin(sin1), .ssel(ssel1),
        .saddr(saddr1), .sout(1'b0), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    // results of the last run_frame call
    int   r_done_rel, r_done_cnt, r_rises, r_saddr_err, r_stall_err;
    int   r_high_err, r_sin_err, r_done_ssel_err, r_post_err, r_rd_n;
    int   r_rd_nonzero;
    bit   r_first_ok;
    logic r_bits [256];
    logic [7:0] r_rd_vals [64];

    // Runs one frame on dut: bytes 0x00..0x1F, optional stall before byte
    // stall_at, optional start pulse (addr 2) at cycle poke_at. sout replays
    // 0xA5, 0x3C, ... aligned to the bit about to be clocked.
    task automatic run_frame(input logic [2:0] addr, input int stall_at,
                             input int stall_len, input int poke_at);
        int rel, idx, stall_n, hi_run, after;
        logic prev_sclk, prev_sin;
        logic [7:0] pb;
        bit fin;
        r_done_rel = -1; r_done_cnt = 0; r_rises = 0; r_saddr_err = 0;
        r_stall_err = 0; r_high_err = 0; r_sin_err = 0; r_done_ssel_err = 0;
        r_post_err = 0; r_rd_n = 0; r_rd_nonzero = 0; r_first_ok = 0;
        idx = 0; stall_n = 0; hi_run = 0; after = 0; fin = 0; rel = 0;
        @(negedge clk);
        start = 1'b1; start_addr = addr; byte_valid = 1'b0; sout = 1'b1;
        prev_sclk = 1'b0; prev_sin = sin;
        while (!fin && rel < 3000) begin
            @(negedge clk);
            rel++;
            start = 1'b0;
            if (rel == poke_at) begin
                start = 1'b1; start_addr = 3'd2;
            end
            if (rel == 1) r_first_ok = (ssel === 1'b1) && (byte_ready === 1'b1) && (busy === 1'b1);
            if (saddr !== addr) r_saddr_err++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                if (r_rises < 256) r_bits[r_rises] = sin;
                r_rises++;
            end
            if (sclk === 1'b1 && prev_sclk === 1'b1 && sin !== prev_sin) r_sin_err++;
            if (sclk === 1'b1) hi_run++;
            else begin
                if (prev_sclk === 1'b1 && hi_run != 2) r_high_err++;
                hi_run = 0;
            end
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_done_rel < 0) r_done_rel = rel;
                if (ssel !== 1'b0) r_done_ssel_err++;
            end
            if (rd_valid === 1'b1) begin
                if (r_rd_n < 64) r_rd_vals[r_rd_n] = rd_data;
                r_rd_n++;
            end
            if (rd_data !== 8'h00) r_rd_nonzero++;
            if (r_done_rel >= 0 && rel > r_done_rel) begin
                if (busy !== 1'b0 || ssel !== 1'b0 || sclk !== 1'b0) r_post_err++;
                after++;
                if (after == 5) fin = 1;
            end
            pb = ((r_rises / 8) % 2 == 0) ? 8'hA5 : 8'h3C;
            sout = pb[7 - (r_rises % 8)];
            if (byte_ready === 1'b1 && idx == stall_at && stall_n < stall_len) begin
                byte_valid = 1'b0;
                stall_n++;
                if (sclk !== 1'b0 || ssel !== 1'b1) r_stall_err++;
            end else begin
                byte_valid = (idx < 32);
                byte_in = 8'(idx);
                if (byte_ready === 1'b1 && byte_valid) idx++;
            end
            prev_sclk = sclk; prev_sin = sin;
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({byte_ready, busy, done, sclk, sin, ssel, saddr, rd_valid, rd_data} !== 17'd0)
            $display("FAIL reset_outputs got=%h want=0",
                     {byte_ready, busy, done, sclk, sin, ssel, saddr, rd_valid, rd_data});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({byte_ready1, busy1, done1, sclk1, sin1, ssel1, saddr1, rd_valid1, rd_data1} !== 17'd0)
            $display("FAIL reset_outputs_div1 got=%h want=0",
                     {byte_ready1, busy1, done1, sclk1, sin1, ssel1, saddr1, rd_valid1, rd_data1});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || ssel !== 1'b0) $display("FAIL idle_after_reset busy=%b ssel=%b want 0/0", busy, ssel);
        else pass_cnt++;
    endtask

    task automatic check_bits(input string name);
        int err;
        logic [7:0] b;
        err = 0;
        for (int j = 0; j < 256; j++) begin
            b = 8'(j / 8);
            if (r_bits[j] !== b[7 - (j % 8)]) err++;
        end
        total_cnt++;
        if (err != 0) $display("FAIL %s bit_errors=%0d want 0", name, err);
        else pass_cnt++;
    endtask

    task automatic test_frame();
        run_frame(3'd5, -1, 0, -1);
        total_cnt++;
        if (!r_first_ok) $display("FAIL first_load_cycle ssel/byte_ready/busy not all 1, want 1");
        else pass_cnt++;
        total_cnt++;
        if (r_saddr_err != 0) $display("FAIL saddr_hold bad_cycles=%0d want 0", r_saddr_err);
        else pass_cnt++;
        total_cnt++;
        if (r_rises != 256) $display("FAIL sclk_rises got=%0d want 256", r_rises);
        else pass_cnt++;
        check_bits("frame_bits");
        total_cnt++;
        if (r_done_rel != 1057) $display("FAIL done_time got=T+%0d want T+1057", r_done_rel);
        else pass_cnt++;
        total_cnt++;
        if (r_done_cnt != 1 || r_done_ssel_err != 0 || r_post_err != 0)
            $display("FAIL done_pulse count=%0d ssel_err=%0d post_err=%0d want 1/0/0",
                     r_done_cnt, r_done_ssel_err, r_post_err);
        else pass_cnt++;
        total_cnt++;
        if (r_high_err != 0 || r_sin_err != 0)
            $display("FAIL half_period high_err=%0d sin_change=%0d want 0/0", r_high_err, r_sin_err);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        run_frame(3'd5, 3, 20, -1);
        total_cnt++;
        if (r_stall_err != 0) $display("FAIL stall_levels bad_cycles=%0d want 0", r_stall_err);
        else pass_cnt++;
        total_cnt++;
        if (r_done_rel != 1077) $display("FAIL stall_done_time got=T+%0d want T+1077", r_done_rel);
        else pass_cnt++;
        check_bits("stall_bits");
    endtask

    task automatic test_start_while_busy();
        run_frame(3'd5, -1, 0, 500);
        total_cnt++;
        if (r_saddr_err != 0) $display("FAIL busy_start_saddr bad_cycles=%0d want 0", r_saddr_err);
        else pass_cnt++;
        total_cnt++;
        if (r_done_cnt != 1 || r_done_rel != 1057 || r_post_err != 0)
            $display("FAIL busy_start_done count=%0d at=T+%0d post_err=%0d want 1/1057/0",
                     r_done_cnt, r_done_rel, r_post_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int idx, rel;
        bit hit;
        idx = 0; rel = 0; hit = 0;
        @(negedge clk);
        start = 1'b1; start_addr = 3'd4;
        while (!hit && rel < 2000) begin
            @(negedge clk);
            rel++;
            start = 1'b0;
            if (idx == 11 && sclk === 1'b1) hit = 1;
            else begin
                byte_valid = 1'b1; byte_in = 8'(idx);
                if (byte_ready === 1'b1) idx++;
            end
        end
        byte_valid = 1'b0;
        total_cnt++;
        if (!hit) $display("FAIL reset_mid_reach_high byte10 HIGH not seen within %0d cycles", rel);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({sclk, ssel, busy, byte_ready, saddr} !== 7'd0)
            $display("FAIL reset_mid_async sclk/ssel/busy/ready/saddr=%b want 0", {sclk, ssel, busy, byte_ready, saddr});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(3'd6, -1, 0, -1);
        total_cnt++;
        if (r_done_rel != 1057 || r_rises != 256 || r_saddr_err != 0)
            $display("FAIL reset_mid_refresh done=T+%0d rises=%0d saddr_err=%0d want 1057/256/0",
                     r_done_rel, r_rises, r_saddr_err);
        else pass_cnt++;
        check_bits("reset_mid_bits");
    endtask

    task automatic test_div1();
        int rel, rises, done_rel, hi_run, lo_run, hi_err, lo1, lo2, lo_bad, after;
        logic prev;
        rel = 0; rises = 0; done_rel = -1; hi_run = 0; lo_run = 0;
        hi_err = 0; lo1 = 0; lo2 = 0; lo_bad = 0; after = 0; prev = 1'b0;
        @(negedge clk);
        start1 = 1'b1; byte_valid1 = 1'b1;
        while (after < 3 && rel < 1500) begin
            @(negedge clk);
            rel++;
            start1 = 1'b0;
            if (sclk1 === 1'b1) begin
                if (prev === 1'b0) begin
                    if (rises > 0) begin
                        if (lo_run == 1) lo1++;
                        else if (lo_run == 2) lo2++;
                        else lo_bad++;
                    end
                    rises++;
                end
                hi_run++;
            end else begin
                if (prev === 1'b1 && hi_run != 1) hi_err++;
                if (prev === 1'b1) lo_run = 0;
                hi_run = 0;
                lo_run++;
            end
            if (done1 === 1'b1 && done_rel < 0) done_rel = rel;
            if (done_rel >= 0 && rel > done_rel) after++;
            prev = sclk1;
        end
        byte_valid1 = 1'b0;
        total_cnt++;
        if (done_rel != 545) $display("FAIL div1_done_time got=T+%0d want T+545", done_rel);
        else pass_cnt++;
        total_cnt++;
        if (rises != 256 || hi_err != 0)
            $display("FAIL div1_sclk rises=%0d high_err=%0d want 256/0", rises, hi_err);
        else pass_cnt++;
        total_cnt++;
        if (lo1 != 224 || lo2 != 31 || lo_bad != 0)
            $display("FAIL div1_low_runs one=%0d two=%0d other=%0d want 224/31/0", lo1, lo2, lo_bad);
        else pass_cnt++;
    endtask

    task automatic test_readback();
        int err;
        logic [7:0] w;
        run_frame(3'd3, -1, 0, -1);
`ifdef SCAN_READBACK_EN
        err = 0;
        for (int i = 0; i < 32 && i < r_rd_n; i++) begin
            w = (i % 2 == 0) ? 8'hA5 : 8'h3C;
            if (r_rd_vals[i] !== w) err++;
        end
        total_cnt++;
        if (r_rd_n != 32) $display("FAIL readback_strobes got=%0d want 32", r_rd_n);
        else pass_cnt++;
        total_cnt++;
        if (err != 0 || r_rd_n == 0)
            $display("FAIL readback_data errors=%0d first=%h want A5/3C pattern", err, r_rd_vals[0]);
        else pass_cnt++;
`else
        err = 0;
        w = 8'h00;
        total_cnt++;
        if (r_rd_n != err || r_rd_nonzero != 0)
            $display("FAIL readback_tied strobes=%0d nonzero_cycles=%0d want 0/0", r_rd_n, r_rd_nonzero);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== w) $display("FAIL readback_data_zero got=%h want 00", rd_data);
        else pass_cnt++;
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_frame();
        test_stall();
        test_start_while_busy();
        test_reset_mid();
        test_div1();
        test_readback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scan_loader.md
# scan_loader

Upstream serial-scan master for the pattern buffer bank. Accepts a load command and a byte stream from the host/control side. Generates the `sclk`/`sin`/`ssel`/`saddr` scan signals that shift one full pattern buffer into the selected buffer chain. Optionally captures the bank's `sout` readback stream into bytes.

## Interface
Parameters:
- `buffer_size`, 32, bytes per pattern buffer (frame length in bytes)
- `buffer_width`, 8, bits per byte; fixed at 8 for this block
- `sclk_div`, 2, `clk` cycles per `sclk` half-period; must be ≥1

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk` input 1 — system clock; all logic is on its rising edge
- `rst_n` input 1 — asynchronous active-low reset
- `start` input 1 — request a frame load; sampled only while idle
- `start_addr` input 3 — target buffer index, latched at `start`
- `byte_in` input 8 — next frame byte; byte 0 first
- `byte_valid` input 1 — `byte_in` is valid
- `byte_ready` output 1 — loader accepts `byte_in` this cycle
- `busy` output 1 — a frame is in progress
- `done` output 1 — one-cycle pulse at frame completion
- `sclk` output 1 — scan clock to the buffers
- `sin` output 1 — scan data to the buffers
- `ssel` output 1 — scan enable
- `saddr` output 3 — scan buffer select
- `sout` input 1 — scan data returned from the buffers
- `rd_data` output 8 — captured readback byte (`SCAN_READBACK_EN` only)
- `rd_valid` output 1 — one-cycle strobe for `rd_data` (`SCAN_READBACK_EN` only)

## Operation
- Reset values: all outputs are 0, and the state is IDLE.
- States:
  - IDLE: `busy`=0. `start`=1 latches `start_addr` into `saddr` and moves to LOAD.
  - LOAD: `ssel`=1, `sclk`=0, `byte_ready`=1.
    - On `byte_valid` & `byte_ready`, the byte goes into the shift register, the bit counter is set to 7, and the state moves to LOW.
    - With no byte available the state stays in LOAD (stall). `sclk` stays low and `ssel` stays high indefinitely.
  - LOW: `sclk`=0 and `sin`=current MSB for `sclk_div` cycles, then HIGH.
  - HIGH: `sclk`=1 and `sin` held for `sclk_div` cycles. At the end of the phase:
    - if bits remain, shift left and return to LOW;
    - else if bytes remain, go to LOAD;
    - else go to FINISH.
  - FINISH: one cycle with `sclk`=0, `ssel`=0, `done`=1, then IDLE.
- Bit order: byte 0 first, MSB first within each byte. A frame is exactly `buffer_size`×8 rising edges of `sclk`.
- Byte counter width is `$clog2(buffer_size)`. The last byte is index `buffer_size`−1; the counter wraps to 0 at FINISH.
- `busy` is 1 in every state except IDLE.
- `start` asserted while busy is ignored and is not queued.
- `byte_valid` outside LOAD is ignored (`byte_ready`=0).
- `saddr` holds its value from the end of the frame until the next `start`.
- `rst_n` low mid-frame: all outputs drop to 0 immediately (asynchronously) and the partial frame is discarded. A glitch-free `sclk` low is guaranteed.

## Timing
- `start` is accepted in cycle T. In T+1 the block is in LOAD with `ssel`=1 and `byte_ready`=1.
- A byte accepted in cycle N gives its MSB on `sin` in N+1. The first `sclk` rise is at N+1+`sclk_div`.
- `sin` changes only in the first cycle of LOW. It is stable for ≥`sclk_div` cycles before and after every `sclk` rise.
- Unstalled byte cost is 1 + 16×`sclk_div` cycles. Unstalled frame with defaults: `start` at T, `done` at T+1+32×33 = T+1057.
- `done` is high in exactly one cycle, coincident with `ssel` falling.

## Configuration
- `SCAN_READBACK_EN` defined:
  - `sout` is sampled in the last cycle of each LOW phase, immediately before the `sclk` rise.
  - Samples are shifted MSB-first into an 8-bit register.
  - After the 8th bit of each byte, `rd_data` is updated and `rd_valid` pulses for 1 cycle, in the cycle after the last sample.
  - There is no backpressure. Exactly `buffer_size` strobes occur per frame.
  - `rd_data` holds its value between strobes and resets to 0.
- `SCAN_READBACK_EN` undefined:
  - `rd_data`/`rd_valid` are tied to 0.
  - `sout` is unused and no capture logic is built.

## Test plan
- Reset, then `start` with `start_addr`=5 and 32 bytes 0x00..0x1F, always valid, defaults:
  - `saddr`=5 for the whole frame;
  - 256 `sclk` rises, with `sin` bit sequence matching bytes MSB-first;
  - `done` exactly at T+1057, then `ssel`=0 and `busy`=0.
- Stall: withhold `byte_valid` for 20 cycles before byte 3:
  - `sclk` stays 0 and `ssel` stays 1 throughout;
  - frame completes 20 cycles later (T+1077) with the same bit sequence.
- Pulse `start` while busy with `start_addr`=2 mid-frame:
  - no effect; `saddr` unchanged;
  - exactly one `done` pulse.
- Drop `rst_n` during the HIGH phase of byte 10:
  - `sclk`, `ssel`, `busy`, `byte_ready` go to 0 without waiting for a clock edge;
  - a new frame after release completes normally.
- `sclk_div`=1: frame completes at T+1+32×17 = T+545, and each `sclk` half-period is 1 cycle.
- With `SCAN_READBACK_EN`, `sout` driven by a bench model replaying 0xA5 then 0x3C:
  - `rd_valid` strobes carry 0xA5 then 0x3C;
  - 32 strobes per frame.
